// File: rtl/mem_stage.sv
// Memory-access pipeline stage: turns EXE load/store/pass-through ops into a
// req/ack data-memory transaction and a registered valid/ready result for WB.
module mem_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int WB_W   = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_read,
    input  logic                  in_write,
    input  logic [1:0]            in_len,
    input  logic                  in_un,
    input  logic [WB_W-1:0]       in_wb,
    input  logic [31:0]           in_addr,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WB_W-1:0]       out_wb,
    output logic [DATA_W-1:0]     out_result,
    output logic                  out_fault
);

    localparam int NB  = DATA_W / 8;
    localparam int OFF = $clog2(NB);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NB-1:0]       be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [OFF-1:0]      lane_q, lane_d;
    logic [1:0]          len_q, len_d;
    logic                un_q, un_d;
    logic [WB_W-1:0]     wb_q, wb_d;
    logic                out_valid_q, out_valid_d;
    logic [WB_W-1:0]     out_wb_q, out_wb_d;
    logic [DATA_W-1:0]   out_result_q, out_result_d;
    logic                out_fault_q, out_fault_d;

    logic                accept;
    logic                isMem;
    logic [2:0]          sizeMask;
    logic                misaligned;
    logic                badLen;
    logic                fault;
    logic [7:0]          beBase;
    logic [NB-1:0]       reqBe;
    logic [DATA_W-1:0]   shifted;
    logic [6:0]          nbits;
    logic [DATA_W-1:0]   extMask;
    logic [DATA_W-1:0]   topBit;
    logic                signBit;
    logic [DATA_W-1:0]   loadData;
    logic                unused_addr;

    assign unused_addr = ^in_addr;

    assign in_ready   = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign isMem      = in_read || in_write;
    assign sizeMask   = 3'((4'd1 << in_len) - 4'd1);
    assign misaligned = |(in_addr[2:0] & sizeMask);
    assign badLen     = (in_len == 2'b11) && (DATA_W != 64);
    assign fault      = (in_read && in_write) || badLen || (isMem && misaligned);

    always_comb begin
        beBase = 8'h01;
        case (in_len)
            2'd0:    beBase = 8'h01;
            2'd1:    beBase = 8'h03;
            2'd2:    beBase = 8'h0F;
            default: beBase = 8'hFF;
        endcase
    end

    assign reqBe = NB'(beBase) << in_addr[OFF-1:0];

    // Load extraction: shift the addressed lane down, then mask to the access
    // size and fill the upper bits with the sign bit unless zero-extending.
    assign shifted  = mem_rdata >> {lane_q, 3'b000};
    assign nbits    = 7'd8 << len_q;
    assign extMask  = (DATA_W'(1) << nbits) - DATA_W'(1);
    assign topBit   = extMask & ~(extMask >> 1);
    assign signBit  = |(shifted & topBit);
    assign loadData = (shifted & extMask) | ((!un_q && signBit) ? ~extMask : '0);

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        data_d       = data_q;
        lane_d       = lane_q;
        len_d        = len_q;
        un_d         = un_q;
        wb_d         = wb_q;
        out_valid_d  = out_valid_q && !out_ready;
        out_wb_d     = out_wb_q;
        out_result_d = out_result_q;
        out_fault_d  = out_fault_q;

        if (accept) begin
            if (fault || !isMem) begin
                out_valid_d  = 1'b1;
                out_wb_d     = in_wb;
                out_result_d = in_data;
                out_fault_d  = fault;
            end else begin
                state_d = ACCESS;
                we_d    = in_write;
                addr_d  = in_addr[OFF+ADDR_W-1:OFF];
                be_d    = in_write ? reqBe : '0;
                wdata_d = in_data << {in_addr[OFF-1:0], 3'b000};
                data_d  = in_data;
                lane_d  = in_addr[OFF-1:0];
                len_d   = in_len;
                un_d    = in_un;
                wb_d    = in_wb;
            end
        end else if (state_q == ACCESS && mem_ack) begin
            state_d      = IDLE;
            out_valid_d  = 1'b1;
            out_wb_d     = wb_q;
            out_result_d = we_q ? data_q : loadData;
            out_fault_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            data_q       <= '0;
            lane_q       <= '0;
            len_q        <= '0;
            un_q         <= 1'b0;
            wb_q         <= '0;
            out_valid_q  <= 1'b0;
            out_wb_q     <= '0;
            out_result_q <= '0;
            out_fault_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            data_q       <= data_d;
            lane_q       <= lane_d;
            len_q        <= len_d;
            un_q         <= un_d;
            wb_q         <= wb_d;
            out_valid_q  <= out_valid_d;
            out_wb_q     <= out_wb_d;
            out_result_q <= out_result_d;
            out_fault_q  <= out_fault_d;
        end
    end

    assign mem_req    = (state_q == ACCESS);
    assign mem_we     = mem_req && we_q;
    assign mem_addr   = addr_q;
    assign mem_be     = be_q;
    assign mem_wdata  = wdata_q;
    assign out_valid  = out_valid_q;
    assign out_wb     = out_wb_q;
    assign out_result = out_result_q;
    assign out_fault  = out_fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid, inRead, inWrite, inUn;
    logic [1:0]  inLen;
    logic [10:0] inWb;
    logic [31:0] inAddr, inData;
    logic        memAck;
    logic [31:0] memRdata;
    logic        outReady;
    logic        inReady, memReq, memWe;
    logic [7:0]  memAddr;
    logic [3:0]  memBe;
    logic [31:0] memWdata;
    logic        outValid, outFault;
    logic [10:0] outWb;
    logic [31:0] outResult;

    logic        v64, r64, w64, un64, ack64, oReady64;
    logic [1:0]  len64;
    logic [31:0] addr64;
    logic [63:0] data64, rdata64;
    logic        ready64, req64, we64, oValid64, oFault64;
    logic [7:0]  maddr64, be64;
    logic [63:0] wdata64, oResult64;
    logic [10:0] oWb64;

    int testsRun = 0;
    int testsFailed = 0;

    bit        mBusy, mWrite, mUn, mValid, mFault;
    bit [1:0]  mLen;
    bit [31:0] mAddr, mData, mResult;
    bit [10:0] mWb, mOpWb;

    always #5 clk = ~clk;

    mem_stage #(.DATA_W(32), .ADDR_W(8), .WB_W(11)) dut (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
        .in_read(inRead), .in_write(inWrite), .in_len(inLen), .in_un(inUn),
        .in_wb(inWb), .in_addr(inAddr), .in_data(inData),
        .mem_req(memReq), .mem_we(memWe), .mem_addr(memAddr), .mem_be(memBe),
        .mem_wdata(memWdata), .mem_ack(memAck), .mem_rdata(memRdata),
        .out_valid(outValid), .out_ready(outReady), .out_wb(outWb),
        .out_result(outResult), .out_fault(outFault)
    );

    mem_stage #(.DATA_W(64), .ADDR_W(8), .WB_W(11)) dut64 (
        .clk(clk), .rst(rst), .in_valid(v64), .in_ready(ready64),
        .in_read(r64), .in_write(w64), .in_len(len64), .in_un(un64),
        .in_wb(11'h0), .in_addr(addr64), .in_data(data64),
        .mem_req(req64), .mem_we(we64), .mem_addr(maddr64), .mem_be(be64),
        .mem_wdata(wdata64), .mem_ack(ack64), .mem_rdata(rdata64),
        .out_valid(oValid64), .out_ready(oReady64), .out_wb(oWb64),
        .out_result(oResult64), .out_fault(oFault64)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic bit [31:0] loadValue(input bit [31:0] rdata, input bit [31:0] addr,
                                            input bit [1:0] len, input bit un);
        int nbytes;
        bit [63:0] mask, raw;
        nbytes = 1 << len;
        mask = (64'd1 << (8 * nbytes)) - 64'd1;
        raw = ({32'd0, rdata} >> (8 * (addr % 4))) & mask;
        if (!un && raw[8 * nbytes - 1]) raw = raw | ~mask;
        return raw[31:0];
    endfunction

    function automatic bit isFault(input bit rd, input bit wr, input bit [1:0] len, input bit [31:0] addr);
        int nbytes;
        nbytes = 1 << len;
        return (rd && wr) || (len == 2'd3) || ((rd || wr) && (addr % nbytes) != 0);
    endfunction

    // Transaction-level model: one pending memory op at most, one result slot.
    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            mBusy = 0; mWrite = 0; mUn = 0; mValid = 0; mFault = 0;
            mLen = 0; mAddr = 0; mData = 0; mResult = 0; mWb = 0; mOpWb = 0;
        end else begin
            acc = inValid && !mBusy && (!mValid || outReady);
            if (mValid && outReady) mValid = 0;
            if (acc) begin
                if (isFault(inRead, inWrite, inLen, inAddr)) begin
                    mValid = 1; mResult = inData; mWb = inWb; mFault = 1;
                end else if (!inRead && !inWrite) begin
                    mValid = 1; mResult = inData; mWb = inWb; mFault = 0;
                end else begin
                    mBusy = 1; mWrite = inWrite; mLen = inLen; mUn = inUn;
                    mAddr = inAddr; mData = inData; mOpWb = inWb;
                end
            end else if (mBusy && memAck) begin
                mBusy = 0; mValid = 1; mWb = mOpWb; mFault = 0;
                mResult = mWrite ? mData : loadValue(memRdata, mAddr, mLen, mUn);
            end
        end
    end

    always @(negedge clk) begin
        bit [3:0] expBe;
        int lane;
        checkOutput("in_ready", inReady, !mBusy && (!mValid || outReady));
        checkOutput("mem_req", memReq, mBusy);
        checkOutput("mem_we", memWe, mBusy && mWrite);
        checkOutput("out_valid", outValid, mValid);
        if (mBusy) begin
            lane = mAddr % 4;
            expBe = mWrite ? 4'(((1 << (1 << mLen)) - 1) << lane) : 4'd0;
            checkOutput("mem_addr", memAddr, (mAddr >> 2) & 32'hFF);
            checkOutput("mem_be", memBe, expBe);
            for (int b = 0; b < 4; b++)
                if (expBe[b]) checkOutput("mem_wdata lane", memWdata[8*b +: 8], mData[8*(b-lane) +: 8]);
        end
        if (mValid) begin
            checkOutput("out_wb", outWb, mWb);
            checkOutput("out_result", outResult, mResult);
            checkOutput("out_fault", outFault, mFault);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit v, input bit rd, input bit wr, input bit [1:0] len,
                                 input bit un, input bit [10:0] wb, input bit [31:0] addr,
                                 input bit [31:0] data);
        inValid = v; inRead = rd; inWrite = wr; inLen = len;
        inUn = un; inWb = wb; inAddr = addr; inData = data;
    endtask

    task automatic doLoad(input bit [31:0] addr, input bit [1:0] len, input bit un,
                          input bit [31:0] exp, input string name);
        tick();
        applyStimulus(1, 1, 0, len, un, 11'h3C, addr, 32'h12345678);
        memRdata = 32'h80FF7F81;
        memAck = 1;
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        memAck = 0;
        @(negedge clk);
        checkOutput(name, outResult, exp);
        checkOutput({name, " model"}, mResult, exp);
    endtask

    task automatic doFault(input bit rd, input bit wr, input bit [1:0] len,
                           input bit [31:0] addr, input string name);
        tick();
        applyStimulus(1, rd, wr, len, 0, 11'h0F0, addr, 32'hCAFE0001);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput({name, " valid"}, outValid, 1);
        checkOutput({name, " fault"}, outFault, 1);
        checkOutput({name, " req"}, memReq, 0);
        checkOutput({name, " result"}, outResult, 32'hCAFE0001);
    endtask

    task automatic run64(input bit rd, input bit wr, input bit [1:0] len, input bit un,
                         input bit [31:0] addr, input bit [63:0] data, input bit [63:0] rdata,
                         input bit [7:0] expBe, input bit [7:0] expAddr,
                         input bit [63:0] expWdata, input bit [63:0] expResult, input string name);
        bit [63:0] mask;
        tick();
        v64 = 1; r64 = rd; w64 = wr; len64 = len; un64 = un; addr64 = addr; data64 = data;
        ack64 = 0;
        tick();
        v64 = 0;
        @(negedge clk);
        mask = 0;
        for (int b = 0; b < 8; b++) if (expBe[b]) mask[8*b +: 8] = 8'hFF;
        checkOutput({name, " req"}, req64, 1);
        checkOutput({name, " we"}, we64, wr);
        checkOutput({name, " be"}, be64, expBe);
        checkOutput({name, " addr"}, maddr64, expAddr);
        checkOutput({name, " wdata"}, wdata64 & mask, expWdata);
        ack64 = 1;
        rdata64 = rdata;
        tick();
        ack64 = 0;
        @(negedge clk);
        checkOutput({name, " valid"}, oValid64, 1);
        checkOutput({name, " result"}, oResult64, expResult);
        checkOutput({name, " fault"}, oFault64, 0);
    endtask

    initial begin
        bit [1:0] len;
        bit [31:0] a;
        int sel;

        rst = 1; outReady = 1; memAck = 0; memRdata = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        v64 = 0; r64 = 0; w64 = 0; un64 = 0; ack64 = 0; oReady64 = 1;
        len64 = 0; addr64 = 0; data64 = 0; rdata64 = 0;
        repeat (2) tick();
        rst = 0;
        @(negedge clk);
        checkOutput("reset out_valid", outValid, 0);
        checkOutput("reset mem_req", memReq, 0);
        checkOutput("reset mem_be", memBe, 0);
        checkOutput("reset mem_addr", memAddr, 0);
        checkOutput("reset out_result", outResult, 0);
        checkOutput("reset in_ready", inReady, 1);

        tick();
        applyStimulus(1, 0, 0, 0, 0, 11'h155, 32'h0, 32'hDEADBEEF);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("pass valid", outValid, 1);
        checkOutput("pass result", outResult, 32'hDEADBEEF);
        checkOutput("pass wb", outWb, 11'h155);
        checkOutput("pass req", memReq, 0);

        tick();
        applyStimulus(1, 0, 1, 2'd0, 0, 11'h001, 32'h6, 32'h000000A5);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("store req held", memReq, 1);
            checkOutput("store be held", memBe, 4'b0100);
            checkOutput("store addr", memAddr, 8'h01);
            checkOutput("store lane data", memWdata[23:16], 8'hA5);
        end
        memAck = 1;
        tick();
        memAck = 0;
        @(negedge clk);
        checkOutput("store out_valid", outValid, 1);
        checkOutput("store result", outResult, 32'hA5);
        checkOutput("store req dropped", memReq, 0);

        doLoad(32'h10, 2'd0, 0, 32'hFFFFFF81, "byte load sext");
        doLoad(32'h2,  2'd1, 0, 32'hFFFF80FF, "half load sext");
        doLoad(32'h2,  2'd1, 1, 32'h000080FF, "half load zext");
        doLoad(32'h4,  2'd2, 0, 32'h80FF7F81, "word load");
        doLoad(32'h3,  2'd0, 1, 32'h00000080, "byte3 load zext");

        doFault(1, 0, 2'd1, 32'h3, "misaligned half");
        doFault(1, 0, 2'd3, 32'h0, "dword on 32");
        doFault(1, 1, 2'd2, 32'h0, "read and write");

        tick();
        outReady = 0;
        applyStimulus(1, 0, 0, 0, 0, 11'h0AA, 0, 32'h11111111);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 11'h055, 0, 32'h22222222);
        @(negedge clk);
        checkOutput("bp valid", outValid, 1);
        checkOutput("bp in_ready", inReady, 0);
        checkOutput("bp result", outResult, 32'h11111111);
        tick();
        @(negedge clk);
        checkOutput("bp result held", outResult, 32'h11111111);
        checkOutput("bp wb held", outWb, 11'h0AA);
        tick();
        outReady = 1;
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("replace valid", outValid, 1);
        checkOutput("replace result", outResult, 32'h22222222);
        checkOutput("replace wb", outWb, 11'h055);

        tick();
        applyStimulus(1, 1, 0, 2'd2, 0, 11'h7, 32'h20, 32'h0);
        memAck = 0;
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("pre-reset req", memReq, 1);
        tick();
        rst = 1;
        tick();
        rst = 0;
        memAck = 1;
        @(negedge clk);
        checkOutput("post-reset req", memReq, 0);
        checkOutput("post-reset valid", outValid, 0);
        tick();
        memAck = 0;
        @(negedge clk);
        checkOutput("stray ack valid", outValid, 0);
        checkOutput("stray ack req", memReq, 0);

        run64(1, 0, 2'd3, 0, 32'h8, 64'h0, 64'h8000000012345678, 8'h00, 8'h01,
              64'h0, 64'h8000000012345678, "d64 dword load");
        run64(1, 0, 2'd2, 0, 32'hC, 64'h0, 64'h8765432100000000, 8'h00, 8'h01,
              64'h0, 64'hFFFFFFFF87654321, "d64 word load");
        run64(0, 1, 2'd1, 0, 32'h6, 64'hBEEF, 64'h0, 8'hC0, 8'h00,
              64'hBEEF000000000000, 64'hBEEF, "d64 half store");

        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            rst = ($urandom_range(0, 199) == 0);
            sel = $urandom_range(0, 9);
            len = 2'($urandom_range(0, 3));
            if (len == 2'd3 && $urandom_range(0, 3) != 0) len = 2'd2;
            a = $urandom;
            if ($urandom_range(0, 9) < 7) a = a & ~((32'd1 << len) - 32'd1);
            applyStimulus($urandom_range(0, 9) < 6, (sel < 4) || (sel == 9),
                          (sel >= 4 && sel < 8) || (sel == 9), len, 1'($urandom),
                          11'($urandom), a, $urandom);
            outReady = $urandom_range(0, 9) < 7;
            memAck = $urandom_range(0, 9) < 4;
            memRdata = $urandom;
        end
        tick();
        rst = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
